lcd_layer_ctrl: RTL and testbench
=================================

Name: lcd_layer_ctrl

Overview:
- Per-pixel colour scheduler placed upstream of the RGB LCD timing driver.
- Consumes the driver's pixel_xpos/pixel_ypos and returns pixel_data one lcd_clk later.
- Arbitrates NUM_LAYERS rectangular colour windows plus a background colour by fixed priority.
- Window configuration is written to shadow registers via a ready/valid port and applied atomically at end of frame, so a frame never shows a mix of old and new settings.

Parameters:
- NUM_LAYERS, 4, number of rectangular layers; highest index has highest priority.
- H_DISP, 11'd800, active pixels per line; xpos valid range 1..H_DISP.
- V_DISP, 11'd480, active lines; ypos valid range 1..V_DISP.
- ADDR_W, 5, config address width; must satisfy 2^ADDR_W >= NUM_LAYERS*4+2.

Ports:
- lcd_clk  input  1  pixel clock; same clock as the LCD timing driver.
- sys_rst  input  1  synchronous, active-high reset.
- pixel_xpos  input  11  driver x coordinate; 0 = blanking, 1..H_DISP = active.
- pixel_ypos  input  11  driver y coordinate; 0 = blanking, 1..V_DISP = active.
- pixel_data  output  24  RGB888 colour to the driver, registered.
- cfg_wr_en  input  1  config write request (valid).
- cfg_addr  input  ADDR_W  config register address.
- cfg_wdata  input  24  config write data.
- cfg_commit  input  1  request shadow-to-active transfer at next frame end.
- cfg_ready  output  1  high when writes and commits are accepted.
- commit_done  output  1  one-cycle pulse when the active set is updated.

Behaviour:
- Clock and reset: single clock lcd_clk. sys_rst is synchronous, active-high.
- Reset values: pixel_data=0, cfg_ready=1, commit_done=0. All shadow and active registers are 0, so every layer is disabled and the background is black.
- Register map, layer L at base L*4:
  - +0: {x0,y0}, bits [21:11] = x, [10:0] = y.
  - +1: {x1,y1}, same packing.
  - +2: colour[23:0].
  - +3: bit0 = enable.
  - NUM_LAYERS*4: background colour.
  - NUM_LAYERS*4+1: control register, bit0 = test pattern.
  - Unmapped addresses: write accepted, no effect.
- Write handshake: a write is accepted only when cfg_wr_en && cfg_ready. Writes seen while cfg_ready=0 are dropped; the requester holds cfg_wr_en until ready.
- Commit FSM, states IDLE and PENDING:
  - IDLE -> PENDING on cfg_commit && cfg_ready. cfg_ready=0 while in PENDING.
  - PENDING -> IDLE on the cycle after the driver presents (xpos==H_DISP, ypos==V_DISP). That cycle copies shadow to active and pulses commit_done.
  - cfg_commit while PENDING is ignored.
  - A write and a commit accepted in the same cycle: the write lands in shadow first and is included in the commit.
- Pixel pipeline, 1-cycle latency:
  - Active pixel = xpos!=0 && ypos!=0.
  - Layer hit = enable && x0<=x<=x1 && y0<=y<=y1. Comparisons are unsigned 11-bit and inclusive.
  - A window with x0>x1 or y0>y1 never hits.
  - Colour = highest-index hit layer's colour, otherwise background.
  - Blanking cycle -> pixel_data=0 on the next cycle.
- Only the active register set feeds the pipeline. Shadow writes never change the visible output mid-frame.
- Reset mid-frame: output becomes 0 and the FSM returns to IDLE. The driver keeps running; the next active pixel uses the reset defaults, i.e. black background.

Optional Feature:
- Macro LCD_TEST_PATTERN_EN.
- When defined: control bit0 in the active set replaces the layer output with 8 vertical colour bars, each H_DISP/8 pixels wide, selected by (xpos-1)/(H_DISP/8). Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
- When undefined: control register writes are accepted but ignored, and the logic is absent.

Decomposition:
- Shared package lcd_pkg holds:
  - H_DISP and V_DISP constants.
  - Register offset constants.
  - Layer record typedef {x0,y0,x1,y1,colour,enable}.
  - Commit-state enum.
  - Colour-bar constant table.
- Natural sub-module: lcd_window_hit, a combinational inclusive rectangle compare, instantiated once per layer.

Test Plan:
- Reset, then drive xpos=1, ypos=1 -> pixel_data=0 one cycle later; cfg_ready=1.
- Write layer0 = (10,10)-(20,20), colour 24'hFF0000, enable; write bg 24'h0000FF; commit. Then:
  - At frame end, commit_done pulses once.
  - Next frame, (10,10) -> 24'hFF0000.
  - (21,10) -> 24'h0000FF.
  - xpos=0 -> 24'h000000.
- Layer1 (15,15)-(30,30) colour 24'h00FF00 overlapping layer0 -> (15,15) gives 24'h00FF00; (12,12) gives 24'hFF0000.
- Commit pending mid-frame, then write layer0 colour -> cfg_ready=0, write dropped, layer0 colour unchanged after commit.
- Write shadow colour without commit -> output unchanged for 2 full frames.
- With LCD_TEST_PATTERN_EN: set control bit0, commit -> xpos=1 gives 24'hFFFFFF; xpos=101 gives 24'hFFFF00; xpos=800 gives 24'h000000.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: constants, register map offsets, layer record, commit-state enum and
// the colour-bar table shared by the LCD layer controller files.
package lcd_pkg;

  localparam logic [10:0] LCD_H_DISP = 11'd800;
  localparam logic [10:0] LCD_V_DISP = 11'd480;

  // Per-layer register offsets (layer L lives at L*4 + offset)
  localparam logic [1:0] OFS_P0     = 2'd0;
  localparam logic [1:0] OFS_P1     = 2'd1;
  localparam logic [1:0] OFS_COLOUR = 2'd2;
  localparam logic [1:0] OFS_EN     = 2'd3;

  // Global registers, relative to NUM_LAYERS*4
  localparam int REG_BG_OFS   = 0;
  localparam int REG_CTRL_OFS = 1;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [23:0] colour;
    logic        enable;
  } layer_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_st_t;

  // Element 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] BAR_COLOUR = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/lcd_window_hit.sv
// lcd_window_hit: combinational inclusive rectangle test for one layer.
// Ports: i_x/i_y pixel coordinate, i_layer layer record, o_hit high when the
// layer is enabled and x0<=x<=x1, y0<=y<=y1 (an inverted window never hits).
module lcd_window_hit
  import lcd_pkg::*;
(
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  layer_t      i_layer,
  output logic        o_hit
);

  assign o_hit = i_layer.enable
              && (i_x >= i_layer.x0) && (i_x <= i_layer.x1)
              && (i_y >= i_layer.y0) && (i_y <= i_layer.y1);

endmodule

// File: rtl/lcd_layer_ctrl.sv
// lcd_layer_ctrl: per-pixel colour scheduler in front of the RGB LCD driver.
// Ports: lcd_clk/sys_rst (sync, active-high); pixel_xpos/pixel_ypos from the
// driver; pixel_data registered RGB888, one cycle after the coordinate;
// cfg_wr_en/cfg_addr/cfg_wdata shadow-register write port with cfg_ready;
// cfg_commit requests a shadow->active copy at frame end, commit_done pulses
// when the active set changes.
// Optional: define LCD_TEST_PATTERN_EN to enable the 8-bar test pattern
// selected by control register bit0.
//
// Commit FSM
//   state      | meaning
//   ST_IDLE    | accepting writes and commits, cfg_ready=1
//   ST_PENDING | commit requested, waiting for last active pixel, cfg_ready=0
module lcd_layer_ctrl
  import lcd_pkg::*;
#(
  parameter int          NUM_LAYERS = 4,
  parameter logic [10:0] H_DISP     = LCD_H_DISP,
  parameter logic [10:0] V_DISP     = LCD_V_DISP,
  parameter int          ADDR_W     = 5
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  output logic [23:0]       pixel_data,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [23:0]       cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_ready,
  output logic              commit_done
);

  layer_t      r_shd_layer [NUM_LAYERS];
  layer_t      r_act_layer [NUM_LAYERS];
  logic [23:0] r_shd_bg;
  logic [23:0] r_act_bg;
`ifdef LCD_TEST_PATTERN_EN
  logic        r_shd_ctrl;
  logic        r_act_ctrl;
  logic [2:0]  w_bar_sel;
`endif

  commit_st_t  r_state;
  commit_st_t  w_state_nxt;
  logic        w_cfg_ready;
  logic        w_do_copy;
  logic        w_wr_acc;
  logic        r_last_px;
  logic        r_commit_done;
  logic [23:0] r_pixel_data;

  logic [NUM_LAYERS-1:0] w_hit;
  logic [23:0]           w_layer_colour;
  logic [23:0]           w_pix_colour;
  logic                  w_active_px;

  assign w_wr_acc = cfg_wr_en && w_cfg_ready;

  // Shadow register writes
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_shd_layer[i] <= '0;
      r_shd_bg <= '0;
`ifdef LCD_TEST_PATTERN_EN
      r_shd_ctrl <= 1'b0;
`endif
    end else if (w_wr_acc) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_addr[ADDR_W-1:2] == (ADDR_W-2)'(i)) begin
          case (cfg_addr[1:0])
            OFS_P0: begin
              r_shd_layer[i].x0 <= cfg_wdata[21:11];
              r_shd_layer[i].y0 <= cfg_wdata[10:0];
            end
            OFS_P1: begin
              r_shd_layer[i].x1 <= cfg_wdata[21:11];
              r_shd_layer[i].y1 <= cfg_wdata[10:0];
            end
            OFS_COLOUR: r_shd_layer[i].colour <= cfg_wdata;
            OFS_EN:     r_shd_layer[i].enable <= cfg_wdata[0];
          endcase
        end
      end
      if (cfg_addr == ADDR_W'(NUM_LAYERS*4 + REG_BG_OFS)) r_shd_bg <= cfg_wdata;
`ifdef LCD_TEST_PATTERN_EN
      if (cfg_addr == ADDR_W'(NUM_LAYERS*4 + REG_CTRL_OFS)) r_shd_ctrl <= cfg_wdata[0];
`endif
    end
  end

  // Active set only changes at frame end, so a frame is never a mix
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_act_layer[i] <= '0;
      r_act_bg <= '0;
`ifdef LCD_TEST_PATTERN_EN
      r_act_ctrl <= 1'b0;
`endif
    end else if (w_do_copy) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_act_layer[i] <= r_shd_layer[i];
      r_act_bg <= r_shd_bg;
`ifdef LCD_TEST_PATTERN_EN
      r_act_ctrl <= r_shd_ctrl;
`endif
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_do_copy   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_ready = 1'b1;
        if (cfg_commit) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (r_last_px) begin
          w_do_copy   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_last_px marks that the previous coordinate was the frame's last pixel
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      r_last_px     <= 1'b0;
      r_commit_done <= 1'b0;
      r_pixel_data  <= '0;
    end else begin
      r_last_px     <= (pixel_xpos == H_DISP) && (pixel_ypos == V_DISP);
      r_commit_done <= w_do_copy;
      r_pixel_data  <= w_active_px ? w_pix_colour : 24'h000000;
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_hit
    lcd_window_hit u_hit (
      .i_x     (pixel_xpos),
      .i_y     (pixel_ypos),
      .i_layer (r_act_layer[g]),
      .o_hit   (w_hit[g])
    );
  end

  assign w_active_px = (pixel_xpos != 11'd0) && (pixel_ypos != 11'd0);

  // Ascending scan: the last hit assigned is the highest-index layer
  always_comb begin
    w_layer_colour = r_act_bg;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_hit[i]) w_layer_colour = r_act_layer[i].colour;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  assign w_bar_sel    = 3'((pixel_xpos - 11'd1) / (H_DISP >> 3));
  assign w_pix_colour = r_act_ctrl ? BAR_COLOUR[w_bar_sel] : w_layer_colour;
`else
  assign w_pix_colour = w_layer_colour;
`endif

  assign pixel_data  = r_pixel_data;
  assign cfg_ready   = w_cfg_ready;
  assign commit_done = r_commit_done;

endmodule

// File: tb/tb_lcd_layer_ctrl.sv
module tb_lcd_layer_ctrl;
  localparam int NL = 4;
  localparam int H  = 800;
  localparam int V  = 480;

  logic        lcd_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [10:0] pixel_xpos = '0;
  logic [10:0] pixel_ypos = '0;
  logic [23:0] pixel_data;
  logic        cfg_wr_en = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [23:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_ready;
  logic        commit_done;

  always #5 lcd_clk = ~lcd_clk;

  lcd_layer_ctrl dut (
    .lcd_clk     (lcd_clk),
    .sys_rst     (sys_rst),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .pixel_data  (pixel_data),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .cfg_ready   (cfg_ready),
    .commit_done (commit_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: shadow/active windows as plain integers
  typedef struct {
    int          x0, y0, x1, y1;
    logic [23:0] col;
    bit          en;
  } mlayer_t;

  mlayer_t     m_sh [NL];
  mlayer_t     m_act[NL];
  logic [23:0] m_sh_bg, m_act_bg;
  bit          m_sh_tp, m_act_tp;
  bit          m_pend, m_prev_end;
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    int          ph;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 24'h0, 1'b0};
      m_act[i] = '{0, 0, 0, 0, 24'h0, 1'b0};
    end
    m_sh_bg = '0; m_act_bg = '0; m_sh_tp = 0; m_act_tp = 0;
    m_pend = 0; m_prev_end = 0;
  endfunction

  function automatic void model_write(int addr, logic [23:0] d);
    if (addr < NL*4) begin
      int l = addr / 4;
      case (addr % 4)
        0: begin m_sh[l].x0 = int'(d[21:11]); m_sh[l].y0 = int'(d[10:0]); end
        1: begin m_sh[l].x1 = int'(d[21:11]); m_sh[l].y1 = int'(d[10:0]); end
        2: m_sh[l].col = d;
        default: m_sh[l].en = d[0];
      endcase
    end else if (addr == NL*4) begin
      m_sh_bg = d;
    end else if (addr == NL*4 + 1) begin
      m_sh_tp = d[0];
    end
  endfunction

  function automatic logic [23:0] ref_px(int x, int y);
    if (x == 0 || y == 0) return 24'h0;
`ifdef LCD_TEST_PATTERN_EN
    if (m_act_tp) return bars[(x - 1) / (H / 8)];
`endif
    for (int l = NL - 1; l >= 0; l--) begin
      if (m_act[l].en && x >= m_act[l].x0 && x <= m_act[l].x1 &&
          y >= m_act[l].y0 && y <= m_act[l].y1)
        return m_act[l].col;
    end
    return m_act_bg;
  endfunction

  function automatic logic [23:0] pk(int x, int y);
    return {2'b00, 11'(x), 11'(y)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One lcd_clk cycle: drive, advance the model, compare everything
  task automatic cycle(input int x, input int y, input bit we = 0, input int addr = 0,
                       input logic [23:0] wd = '0, input bit cm = 0, input bit rst = 0);
    bit          ready;
    bit          exp_done;
    logic [23:0] exp_px;
    pixel_xpos = 11'(x); pixel_ypos = 11'(y);
    cfg_wr_en = we; cfg_addr = 5'(addr); cfg_wdata = wd; cfg_commit = cm; sys_rst = rst;
    ready = !m_pend;
    chk("cfg_ready_pre", {31'b0, cfg_ready}, {31'b0, ready});
    exp_px   = ref_px(x, y);
    exp_done = 0;
    if (rst) begin
      model_reset();
      exp_px = '0;
    end else begin
      if (m_pend && m_prev_end) begin
        m_act = m_sh; m_act_bg = m_sh_bg; m_act_tp = m_sh_tp;
        m_pend = 0; exp_done = 1;
      end
      if (we && ready) model_write(addr, wd);
      if (cm && ready) m_pend = 1;
      m_prev_end = (x == H && y == V);
    end
    @(posedge lcd_clk);
    #1;
    cfg_wr_en = 0; cfg_commit = 0; sys_rst = 0;
    chk("pixel_data", {8'b0, pixel_data}, {8'b0, exp_px});
    chk("commit_done", {31'b0, commit_done}, {31'b0, exp_done});
    chk("cfg_ready_post", {31'b0, cfg_ready}, {31'b0, !m_pend});
  endtask

  task automatic frame_end();
    cycle(H, V);
    cycle(0, 0);
  endtask

  task automatic run_table(input int ph);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ph == ph) begin
        cycle(tbl[i].x, tbl[i].y);
        chk($sformatf("tbl%0d_(%0d,%0d)", ph, tbl[i].x, tbl[i].y),
            {8'b0, pixel_data}, {8'b0, tbl[i].exp});
      end
    end
  endtask

  function automatic int clampx(int v);
    if (v < 0) return 0;
    if (v > H) return H;
    return v;
  endfunction

  initial begin
    tbl[0]  = '{1, 10, 10, 24'hFF0000};
    tbl[1]  = '{1, 21, 10, 24'h0000FF};
    tbl[2]  = '{1,  0, 10, 24'h000000};
    tbl[3]  = '{1, 20, 20, 24'hFF0000};
    tbl[4]  = '{1,  9, 10, 24'h0000FF};
    tbl[5]  = '{1, 10, 21, 24'h0000FF};
    tbl[6]  = '{2, 15, 15, 24'h00FF00};
    tbl[7]  = '{2, 12, 12, 24'hFF0000};
    tbl[8]  = '{2, 30, 30, 24'h00FF00};
    tbl[9]  = '{2, 31, 30, 24'h0000FF};
    tbl[10] = '{2, 20, 20, 24'h00FF00};
    tbl[11] = '{2, 14, 14, 24'hFF0000};

    // Reset
    sys_rst = 1;
    repeat (2) @(posedge lcd_clk);
    #1;
    sys_rst = 0;
    model_reset();
    chk("reset_pixel", {8'b0, pixel_data}, 32'h0);
    chk("reset_ready", {31'b0, cfg_ready}, 32'h1);
    chk("reset_done", {31'b0, commit_done}, 32'h0);
    cycle(1, 1);
    chk("first_pixel_black", {8'b0, pixel_data}, 32'h0);

    // Layer 0 plus background, then commit
    cycle(0, 0, 1, 0, pk(10, 10));
    cycle(0, 0, 1, 1, pk(20, 20));
    cycle(0, 0, 1, 2, 24'hFF0000);
    cycle(0, 0, 1, 3, 24'h000001);
    cycle(0, 0, 1, 16, 24'h0000FF);
    cycle(5, 5, 0, 0, '0, 1);
    chk("pending_not_ready", {31'b0, cfg_ready}, 32'h0);
    cycle(10, 10);
    chk("old_set_until_frame_end", {8'b0, pixel_data}, 32'h0);
    cycle(H, V);
    cycle(0, 0);
    chk("commit_done_pulse", {31'b0, commit_done}, 32'h1);
    cycle(0, 0);
    chk("commit_done_once", {31'b0, commit_done}, 32'h0);
    run_table(1);

    // Layer 1 overlapping, enable written in the same cycle as the commit
    cycle(0, 0, 1, 4, pk(15, 15));
    cycle(0, 0, 1, 5, pk(30, 30));
    cycle(0, 0, 1, 6, 24'h00FF00);
    cycle(0, 0, 1, 7, 24'h000001, 1);
    frame_end();
    run_table(2);

    // Write while commit pending is dropped
    cycle(3, 3, 0, 0, '0, 1);
    cycle(12, 12, 1, 2, 24'h123456);
    chk("drop_ready_low", {31'b0, cfg_ready}, 32'h0);
    frame_end();
    cycle(12, 12);
    chk("dropped_write", {8'b0, pixel_data}, 32'hFF0000);

    // Shadow write without commit stays invisible for two frames
    cycle(0, 0, 1, 2, 24'hABCDEF);
    for (int f = 0; f < 2; f++) begin
      cycle(12, 12);
      chk("shadow_invisible", {8'b0, pixel_data}, 32'hFF0000);
      cycle(H, V);
      cycle(0, 0);
      chk("no_commit_no_done", {31'b0, commit_done}, 32'h0);
    end

    // Reset mid-frame with a commit pending
    cycle(5, 5, 0, 0, '0, 1);
    cycle(12, 12, 0, 0, '0, 0, 1);
    chk("midframe_reset_pixel", {8'b0, pixel_data}, 32'h0);
    chk("midframe_reset_ready", {31'b0, cfg_ready}, 32'h1);
    cycle(12, 12);
    chk("after_reset_black", {8'b0, pixel_data}, 32'h0);

    // Control register / test pattern
    cycle(0, 0, 1, 17, 24'h000001, 1);
    frame_end();
`ifdef LCD_TEST_PATTERN_EN
    cycle(1, 1);   chk("bar_x1",   {8'b0, pixel_data}, 32'hFFFFFF);
    cycle(100, 1); chk("bar_x100", {8'b0, pixel_data}, 32'hFFFFFF);
    cycle(101, 1); chk("bar_x101", {8'b0, pixel_data}, 32'hFFFF00);
    cycle(800, 5); chk("bar_x800", {8'b0, pixel_data}, 32'h000000);
`else
    cycle(1, 1);   chk("ctrl_ignored", {8'b0, pixel_data}, 32'h0);
`endif
    cycle(0, 0, 1, 17, 24'h000000, 1);
    frame_end();

    // Randomized configurations against the model
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < NL; l++) begin
        int x0, y0, x1, y1;
        x0 = $urandom_range(1, H);
        y0 = $urandom_range(1, V);
        x1 = x0 + int'($urandom_range(0, 200)) - 10;
        y1 = y0 + int'($urandom_range(0, 150)) - 10;
        if (x1 < 0) x1 = 0;
        if (y1 < 0) y1 = 0;
        cycle($urandom_range(0, H), $urandom_range(0, V), 1, l*4 + 0, pk(x0, y0));
        cycle($urandom_range(0, H), $urandom_range(0, V), 1, l*4 + 1, pk(x1, y1));
        cycle($urandom_range(0, H), $urandom_range(0, V), 1, l*4 + 2, 24'($urandom));
        cycle($urandom_range(0, H), $urandom_range(0, V), 1, l*4 + 3,
              24'($urandom_range(0, 3) != 0));
      end
      cycle(0, 0, 1, 16, 24'($urandom));
      cycle(0, 0, 1, $urandom_range(18, 31), 24'($urandom));
      cycle(7, 7, 0, 0, '0, 1);
      for (int k = 0; k < 5; k++)
        cycle($urandom_range(1, H), $urandom_range(1, V), 1, $urandom_range(0, 16), 24'($urandom));
      frame_end();
      for (int k = 0; k < 150; k++) begin
        int x, y, l;
        if ($urandom_range(0, 1) == 1) begin
          l = $urandom_range(0, NL - 1);
          x = clampx(($urandom_range(0, 1) ? m_act[l].x0 : m_act[l].x1) + int'($urandom_range(0, 2)) - 1);
          y = ($urandom_range(0, 1) ? m_act[l].y0 : m_act[l].y1) + int'($urandom_range(0, 2)) - 1;
          if (y < 0) y = 0;
          if (y > V) y = V;
        end else begin
          x = $urandom_range(0, H);
          y = $urandom_range(0, V);
        end
        if (x == H && y == V) y = V - 1;
        cycle(x, y);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
